eth_wb_mem_responder: RTL

- WISHBONE B3 slave memory that answers the Ethernet DMA master port (`m_wb_*`): buffer-descriptor payload fetches on Tx, frame writes on Rx.
- Supports classic cycles and incrementing bursts (CTI/BTE), programmable wait states, byte-lane writes and out-of-range error response.
- Used as the system-memory end in MAC-level benches; synthesizable for FPGA bring-up.

---
 rtl/eth_wb_mem_responder.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/eth_wb_mem_responder.sv
// rtl/eth_wb_mem_responder.sv - WISHBONE B3 slave memory answering the Ethernet DMA master
//
// Optional feature macro: ETH_WB_RESP_STALL_EN (pseudo-random ack withholding inside bursts).
//
// Ports:
//   WB_CLK_I            clock, all logic on the rising edge
//   Reset               synchronous active-high reset
//   s_wb_adr_i[29:0]    word address
//   s_wb_sel_i[3:0]     byte selects, bit3 = dat[31:24]
//   s_wb_we_i           1 = write
//   s_wb_dat_i[31:0]    write data
//   s_wb_dat_o[31:0]    read data, valid with ack
//   s_wb_cyc_i          cycle valid
//   s_wb_stb_i          strobe
//   s_wb_cti_i[2:0]     000 classic, 010 incrementing burst, 111 end of burst
//   s_wb_bte_i[1:0]     00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16
//   s_wb_ack_o          normal termination
//   s_wb_err_o          error termination
//   err_cnt_o[7:0]      saturating count of error terminations
module eth_wb_mem_responder #(
   parameter int          MEM_AW      = 10,
   parameter logic [29:0] BASE_ADR    = 30'h0,
   parameter int          WAIT_STATES = 0
) (
   input  logic        WB_CLK_I,
   input  logic        Reset,
   input  logic [29:0] s_wb_adr_i,
   input  logic [3:0]  s_wb_sel_i,
   input  logic        s_wb_we_i,
   input  logic [31:0] s_wb_dat_i,
   output logic [31:0] s_wb_dat_o,
   input  logic        s_wb_cyc_i,
   input  logic        s_wb_stb_i,
   input  logic [2:0]  s_wb_cti_i,
   input  logic [1:0]  s_wb_bte_i,
   output logic        s_wb_ack_o,
   output logic        s_wb_err_o,
   output logic [7:0]  err_cnt_o
);

   localparam int         DEPTH = 1 << MEM_AW;
   localparam logic [3:0] LP_WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_BURST} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [31:0]        r_mem [0:DEPTH-1];
   logic [31:0]        r_dat;
   logic [31:0]        r_pref;
   logic [29:0]        r_ta;
   logic [2:0]         r_cti;
   logic [3:0]         r_wcnt;
   logic [7:0]         r_err_cnt;
   logic               r_ack;
   logic               r_err;

   logic               w_req;
   logic               w_cti_bst;
   logic               w_cti_end;
   logic [29:0]        w_off;
   logic               w_in_rng;
   logic [29:0]        w_ta_nx;
   logic [MEM_AW-1:0]  w_nx_idx;
   logic [MEM_AW-1:0]  w_rd_idx;
   logic               w_issue;
   logic               w_bbeat;
   logic               w_back;
   logic               w_berr;
   logic               w_stall;
   logic               w_wr_en;
   logic               w_ack_o;
   logic               w_err_o;
   logic [31:0]        w_dat_o;

   // Tracker advance: linear increments the whole address, wraps only the low bits.
   function automatic logic [29:0] f_next(input logic [29:0] a, input logic [1:0] bte);
      case (bte)
         2'b01:   f_next = {a[29:2], a[1:0] + 2'd1};
         2'b10:   f_next = {a[29:3], a[2:0] + 3'd1};
         2'b11:   f_next = {a[29:4], a[3:0] + 4'd1};
         default: f_next = a + 30'd1;
      endcase
   endfunction

   assign w_req     = s_wb_cyc_i & s_wb_stb_i;
   assign w_cti_bst = (s_wb_cti_i == 3'b010);
   assign w_cti_end = (s_wb_cti_i == 3'b111);
   assign w_off     = s_wb_adr_i - BASE_ADR;
   assign w_in_rng  = (s_wb_adr_i >= BASE_ADR) && ((w_off >> MEM_AW) == 30'd0);
   assign w_ta_nx   = f_next(r_ta, s_wb_bte_i);
   assign w_nx_idx  = w_ta_nx[MEM_AW-1:0] - BASE_ADR[MEM_AW-1:0];
   // Single read port: classic responses read the presented word, burst states prefetch the next one.
   assign w_rd_idx  = (r_state == S_RESP || r_state == S_BURST) ? w_nx_idx : w_off[MEM_AW-1:0];

   assign w_issue = !Reset && w_req &&
                    ((r_state == S_IDLE && LP_WS == 4'd0) || (r_state == S_WAIT && r_wcnt == 4'd1));

`ifdef ETH_WB_RESP_STALL_EN
   logic [15:0] r_lfsr;
   always_ff @(posedge WB_CLK_I) begin
      if (Reset) r_lfsr <= 16'hACE1;
      else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   end
   assign w_stall = r_lfsr[0];
`else
   assign w_stall = 1'b0;
`endif

   // Burst beats are answered combinationally so the check of adr against the tracker
   // happens on the beat actually presented; data comes from the prefetch register.
   assign w_bbeat = !Reset && (r_state == S_BURST) && w_req && (w_cti_bst || w_cti_end) && !w_stall;
   assign w_back  = w_bbeat && (s_wb_adr_i == r_ta) && w_in_rng;
   assign w_berr  = w_bbeat && !((s_wb_adr_i == r_ta) && w_in_rng);
   assign w_wr_en = s_wb_we_i && ((w_issue && w_in_rng) || w_back);

   always_ff @(posedge WB_CLK_I) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_req) w_next = (LP_WS == 4'd0) ? S_RESP : S_WAIT;
         S_WAIT:  begin
            if (!s_wb_cyc_i)                     w_next = S_IDLE;
            else if (w_req && r_wcnt == 4'd1)    w_next = S_RESP;
         end
         S_RESP:  w_next = (r_cti == 3'b010 && r_ack && s_wb_cyc_i) ? S_BURST : S_IDLE;
         S_BURST: begin
            if (!s_wb_cyc_i)                          w_next = S_IDLE;
            else if (w_req) begin
               if (!(w_cti_bst || w_cti_end))         w_next = S_IDLE;
               else if (w_berr)                       w_next = S_IDLE;
               else if (w_back && w_cti_end)          w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_ack_o = 1'b0;
      w_err_o = 1'b0;
      w_dat_o = r_dat;
      if (!Reset && s_wb_cyc_i) begin
         w_ack_o = (r_state == S_RESP && r_ack) || w_back;
         w_err_o = (r_state == S_RESP && r_err) || w_berr;
      end
      if (w_back)      w_dat_o = r_pref;
      else if (w_berr) w_dat_o = 32'd0;
   end

   always_ff @(posedge WB_CLK_I) begin
      if (Reset) begin
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_dat     <= 32'd0;
         r_pref    <= 32'd0;
         r_ta      <= 30'd0;
         r_cti     <= 3'd0;
         r_wcnt    <= 4'd0;
         r_err_cnt <= 8'd0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         if (r_state == S_IDLE && w_req) begin
            r_ta   <= s_wb_adr_i;
            r_cti  <= s_wb_cti_i;
            r_wcnt <= LP_WS;
         end
         if (r_state == S_WAIT && s_wb_cyc_i && r_wcnt > 4'd1)
            r_wcnt <= r_wcnt - 4'd1;
         if (w_issue) begin
            if (w_in_rng) begin
               r_ack <= 1'b1;
               r_dat <= r_mem[w_rd_idx];
            end else begin
               r_err <= 1'b1;
               r_dat <= 32'd0;
            end
         end
         if (r_state == S_RESP && w_next == S_BURST) begin
            r_ta   <= w_ta_nx;
            r_pref <= r_mem[w_rd_idx];
         end
         if (w_back) begin
            r_dat  <= r_pref;
            r_ta   <= w_ta_nx;
            r_pref <= r_mem[w_rd_idx];
         end
         if (w_berr)
            r_dat <= 32'd0;
         if (w_err_o && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   // RAM is deliberately not reset; unselected byte lanes keep their contents.
   always_ff @(posedge WB_CLK_I) begin
      if (w_wr_en) begin
         for (int b = 0; b < 4; b++)
            if (s_wb_sel_i[b]) r_mem[w_off[MEM_AW-1:0]][8*b +: 8] <= s_wb_dat_i[8*b +: 8];
      end
   end

   assign s_wb_ack_o = w_ack_o;
   assign s_wb_err_o = w_err_o;
   assign s_wb_dat_o = w_dat_o;
   assign err_cnt_o  = r_err_cnt;

endmodule
